ibus_linebuf_responder: RTL and testbench



---
 rtl/ibus_linebuf_responder.sv | 175 +++++++++++++++++
 tb/tb_ibus_linebuf_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ibus_linebuf_responder.sv
// Instruction-bus responder: serves 32-bit fetches from a one-entry 64-bit line buffer or one cbus read.
// Define FETCH_LINEBUF_EN to enable the line-buffer hit path; otherwise every fetch goes to memory.

package common;
  typedef logic [63:0] u64;
  typedef logic [31:0] u32;
  typedef logic [7:0]  strobe_t;

  typedef enum logic [2:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;
  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } mlen_t;
  typedef enum logic [1:0] {AXI_BURST_FIXED, AXI_BURST_INCR, AXI_BURST_WRAP} axi_burst_type_t;

  typedef struct packed {
    logic valid;
    u64   addr;
  } ibus_req_t;

  typedef struct packed {
    logic addr_ok;
    logic data_ok;
    u32   data;
  } ibus_resp_t;

  typedef struct packed {
    logic            valid;
    logic            is_write;
    msize_t          size;
    u64              addr;
    strobe_t         strobe;
    u64              data;
    mlen_t           len;
    axi_burst_type_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic ready;
    logic last;
    u64   data;
  } cbus_resp_t;
endpackage

module ibus_linebuf_responder
  import common::*;
(
  input  logic       clk,
  input  logic       rst,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp,
  input  logic       flush
);

  typedef enum logic [1:0] {StIdle, StFetch, StResp} state_e;

  state_e      r_state;
  state_e      w_state_next;
  u64          r_req_addr;
  logic        r_lb_valid;
  logic [60:0] r_lb_tag;
  u64          r_lb_data;
  logic        r_flush_pend;
  logic        w_hit;
  logic        w_fill_done;
  logic        w_unused;

  assign w_fill_done = cresp.ready && cresp.last;

`ifdef FETCH_LINEBUF_EN
  // A flush in the request cycle forces a miss even if the tag matches.
  assign w_hit    = r_lb_valid && (r_lb_tag == ireq.addr[63:3]) && !flush;
  assign w_unused = ^r_req_addr[1:0];
`else
  assign w_hit    = 1'b0;
  assign w_unused = ^{r_req_addr[1:0], r_lb_tag, r_lb_valid, r_flush_pend, flush};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_req_addr <= '0;
      r_lb_tag   <= '0;
      r_lb_data  <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StIdle && ireq.valid) begin
        r_req_addr <= ireq.addr;
      end
      if (r_state == StFetch && w_fill_done) begin
        r_lb_tag  <= r_req_addr[63:3];
        r_lb_data <= cresp.data;
      end
    end
  end

`ifdef FETCH_LINEBUF_EN
  // The cbus read is never aborted; a flush during FETCH only prevents the fill from validating.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lb_valid   <= 1'b0;
      r_flush_pend <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_flush_pend <= 1'b0;
          if (flush) begin
            r_lb_valid <= 1'b0;
          end
        end
        StFetch: begin
          if (flush) begin
            r_flush_pend <= 1'b1;
          end
          if (w_fill_done) begin
            r_lb_valid <= !(r_flush_pend || flush);
          end
        end
        StResp: begin
          if (flush) begin
            r_lb_valid <= 1'b0;
          end
        end
        default: begin
          r_lb_valid <= 1'b0;
        end
      endcase
    end
  end
`else
  always_ff @(posedge clk) begin
    r_lb_valid   <= 1'b0;
    r_flush_pend <= 1'b0;
  end
`endif

  always_comb begin
    w_state_next = r_state;
    iresp        = '0;
    creq         = '0;
    unique case (r_state)
      StIdle: begin
        if (ireq.valid) begin
          w_state_next = w_hit ? StResp : StFetch;
        end
      end
      StFetch: begin
        creq.valid    = 1'b1;
        creq.is_write = 1'b0;
        creq.size     = MSIZE8;
        creq.addr     = {r_req_addr[63:3], 3'b000};
        creq.len      = MLEN1;
        creq.burst    = AXI_BURST_FIXED;
        if (w_fill_done) begin
          w_state_next = StResp;
        end
      end
      StResp: begin
        iresp.addr_ok = 1'b1;
        iresp.data_ok = 1'b1;
        iresp.data    = r_req_addr[2] ? r_lb_data[63:32] : r_lb_data[31:0];
        w_state_next  = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_ibus_linebuf_responder.sv
// Bench for ibus_linebuf_responder: transaction-level line-buffer model plus per-cycle output compare.
module tb_ibus_linebuf_responder;
  import common::*;

`ifdef FETCH_LINEBUF_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  cbus_req_t  creq;
  cbus_resp_t cresp;
  logic       flush;

  always #5 clk = ~clk;

  ibus_linebuf_responder dut (
    .clk  (clk),
    .rst  (rst),
    .ireq (ireq),
    .iresp(iresp),
    .creq (creq),
    .cresp(cresp),
    .flush(flush)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  // Expected outputs for the current cycle, set by the stimulus tasks.
  ibus_resp_t e_iresp;
  cbus_req_t  e_creq;

  // Model of what the line buffer must contain.
  logic        m_lb_valid;
  logic [60:0] m_lb_tag;
  u64          m_lb_data;

  u32 seen_data;
  u64 seen_caddr;
  int n_creq_cycles = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      n_tests++;
      if (iresp !== e_iresp) begin
        n_fail++;
        $display("FAIL iresp @%0t: got %h want %h", $time, iresp, e_iresp);
      end
      n_tests++;
      if (creq !== e_creq) begin
        n_fail++;
        $display("FAIL creq @%0t: got %h want %h", $time, creq, e_creq);
      end
      if (iresp.data_ok) seen_data = iresp.data;
      if (creq.valid) begin
        seen_caddr = creq.addr;
        n_creq_cycles++;
      end
    end
  end

  task automatic check(input string name, input u64 got, input u64 want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic u64 memval(input u64 a);
    u64 line;
    line = {a[63:3], 3'b000};
    if (line == 64'h8000_0000) return 64'h1111_2222_3333_4444;
    return {line[31:0] ^ 32'hA5A5_0000, ~line[31:0]};
  endfunction

  function automatic u32 pick(input u64 d, input u64 a);
    return a[2] ? d[63:32] : d[31:0];
  endfunction

  task automatic expect_idle();
    e_iresp = '0;
    e_creq  = '0;
  endtask

  task automatic expect_read(input u64 a);
    e_creq       = '0;
    e_creq.valid = 1'b1;
    e_creq.size  = MSIZE8;
    e_creq.addr  = {a[63:3], 3'b000};
    e_creq.len   = MLEN1;
    e_creq.burst = AXI_BURST_FIXED;
  endtask

  // flush_at: -1 none, 0 with the request in IDLE, j>=1 on the j-th FETCH cycle.
  task automatic fetch(input u64 a, input int nwait, input int flush_at);
    logic hit;
    logic fetch_flushed;
    u64   line;
    hit = LB && m_lb_valid && (m_lb_tag == a[63:3]) && (flush_at != 0);
    ireq.valid = 1'b1;
    ireq.addr  = a;
    if (flush_at == 0) flush = 1'b1;
    expect_idle();
    @(posedge clk); #1;
    flush = 1'b0;
    if (flush_at == 0) m_lb_valid = 1'b0;
    if (hit) begin
      e_iresp.addr_ok = 1'b1;
      e_iresp.data_ok = 1'b1;
      e_iresp.data    = pick(m_lb_data, a);
      @(posedge clk); #1;
    end else begin
      expect_read(a);
      line          = memval(a);
      fetch_flushed = 1'b0;
      for (int k = 0; k <= nwait; k++) begin
        if (k == nwait) begin
          cresp.ready = 1'b1;
          cresp.last  = 1'b1;
          cresp.data  = line;
        end
        if (k + 1 == flush_at) begin
          flush         = 1'b1;
          fetch_flushed = 1'b1;
        end
        @(posedge clk); #1;
        cresp = '0;
        flush = 1'b0;
      end
      e_creq          = '0;
      e_iresp.addr_ok = 1'b1;
      e_iresp.data_ok = 1'b1;
      e_iresp.data    = pick(line, a);
      m_lb_tag   = a[63:3];
      m_lb_data  = line;
      m_lb_valid = LB && !fetch_flushed;
      @(posedge clk); #1;
    end
    ireq.valid = 1'b0;
    expect_idle();
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush      = 1'b0;
    m_lb_valid = 1'b0;
  endtask

  // The address must miss in the model so FETCH is entered.
  task automatic reset_mid_fetch(input u64 a);
    ireq.valid = 1'b1;
    ireq.addr  = a;
    expect_idle();
    @(posedge clk); #1;
    expect_read(a);
    @(posedge clk); #1;
    rst        = 1'b1;
    ireq.valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    expect_idle();
    m_lb_valid = 1'b0;
    m_lb_tag   = '0;
    m_lb_data  = '0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int nc;
    rst        = 1'b1;
    ireq       = '0;
    cresp      = '0;
    flush      = 1'b0;
    m_lb_valid = 1'b0;
    m_lb_tag   = '0;
    m_lb_data  = '0;
    seen_data  = '0;
    seen_caddr = '0;
    expect_idle();
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // Cold miss, 3 wait cycles.
    nc = n_creq_cycles;
    fetch(64'h8000_0000, 3, -1);
    check("cold_caddr", seen_caddr, 64'h8000_0000);
    check("cold_data", {32'h0, seen_data}, 64'h3333_4444);
    check("cold_fetch_cycles", 64'(n_creq_cycles - nc), 64'd4);

    // Same-line upper word.
    nc = n_creq_cycles;
    fetch(64'h8000_0004, 0, -1);
    check("hit_data", {32'h0, seen_data}, 64'h1111_2222);
    check("hit_fetch_cycles", 64'(n_creq_cycles - nc), LB ? 64'd0 : 64'd1);

    // Line-boundary miss, then same-line hit on the new tag.
    fetch(64'h8000_0008, 2, -1);
    check("boundary_caddr", seen_caddr, 64'h8000_0008);
    fetch(64'h8000_000C, 0, -1);
    fetch(64'h8000_000B, 0, -1);

    // Flush in IDLE forces a miss.
    pulse_flush();
    nc = n_creq_cycles;
    fetch(64'h8000_000C, 1, -1);
    check("flush_idle_miss", 64'(n_creq_cycles - nc), 64'd2);

    // Flush during FETCH: data returned, line not kept.
    fetch(64'h8000_0010, 3, 2);
    nc = n_creq_cycles;
    fetch(64'h8000_0014, 0, -1);
    check("flush_fetch_remiss", 64'(n_creq_cycles - nc), 64'd1);
    fetch(64'h8000_0010, 0, -1);

    // Flush together with a would-be hit.
    nc = n_creq_cycles;
    fetch(64'h8000_0014, 0, 0);
    check("flush_hit_miss", 64'(n_creq_cycles - nc), 64'd1);

    // Memory withholds ready for 10 cycles.
    nc = n_creq_cycles;
    fetch(64'h8000_0100, 10, -1);
    check("hold_fetch_cycles", 64'(n_creq_cycles - nc), 64'd11);
    fetch(64'h8000_0104, 0, -1);

    // Reset in FETCH, then the previously valid line must miss.
    reset_mid_fetch(64'h8000_0200);
    nc = n_creq_cycles;
    fetch(64'h8000_0100, 0, -1);
    check("post_reset_miss", 64'(n_creq_cycles - nc), 64'd1);
    check("post_reset_caddr", seen_caddr, 64'h8000_0100);

    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
